// File: rtl/adc_align_pkg.sv
// Shared types and constants for the ADC link-alignment controller: FSM states,
// ADC test-pattern and error codes, deskew training words and window helpers.
package adc_align_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DRST,
        SCAN_SETTLE,
        SCAN_CHECK,
        SCAN_STEP,
        CRST,
        CSTEP,
        SYNC_SETTLE,
        SYNC_CHECK,
        SLIP,
        RUN,
        FAIL
    } state_t;

    localparam logic [1:0] PAT_DESKEW = 2'b00;
    localparam logic [1:0] PAT_SYNC   = 2'b01;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_NO_WINDOW = 2'b01;
    localparam logic [1:0] ERR_NO_SYNC   = 2'b10;

    localparam logic [11:0] DESKEW_WORD_A = 12'h555;
    localparam logic [11:0] DESKEW_WORD_B = 12'hAAA;

    function automatic logic is_deskew_word(input logic [11:0] word);
        return (word == DESKEW_WORD_A) || (word == DESKEW_WORD_B);
    endfunction

    // Floor of the window midpoint; the sum is widened so tap 31 + tap 31 cannot wrap.
    function automatic logic [4:0] centre_tap(input logic [4:0] first, input logic [4:0] last);
        return 5'(({1'b0, first} + {1'b0, last}) >> 1);
    endfunction

endpackage

// File: rtl/adc_word_checker.sv
// Qualifies a stream of valid words: discards SETTLE_WORDS, then strobes pass after
// CHECK_WORDS consecutive matches or fail on the first mismatch. Counters clear while idle.
module adc_word_checker #(
    parameter int SETTLE_WORDS = 8,
    parameter int CHECK_WORDS  = 16
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic active,
    input  logic valid,
    input  logic match,
    output logic settle_done,
    output logic pass,
    output logic fail
);

    localparam int SW = $clog2(SETTLE_WORDS + 1);
    localparam int CW = $clog2(CHECK_WORDS + 1);

    logic [SW-1:0] settle_cnt;
    logic [CW-1:0] match_cnt;
    logic          settled;

    assign settled     = (settle_cnt == SW'(SETTLE_WORDS));
    assign settle_done = active && valid && !settled && (settle_cnt == SW'(SETTLE_WORDS - 1));
    assign pass        = active && valid && settled && match && (match_cnt == CW'(CHECK_WORDS - 1));
    assign fail        = active && valid && settled && !match;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            settle_cnt <= '0;
            match_cnt  <= '0;
        end else if (!active) begin
            settle_cnt <= '0;
            match_cnt  <= '0;
        end else if (valid) begin
            if (!settled) begin
                settle_cnt <= settle_cnt + 1'b1;
            end else if (match) begin
                match_cnt <= match_cnt + 1'b1;
            end else begin
                match_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/adc_align_ctrl.sv
// ADC link training: scans delay taps for the deskew eye, centres on it, then
// bitslips until the sync word is found and hands the ADC over to run mode.
module adc_align_ctrl
    import adc_align_pkg::*;
#(
    parameter int          SETTLE_WORDS = 8,
    parameter int          CHECK_WORDS  = 16,
    parameter int          NUM_TAPS     = 32,
    parameter int          MAX_SLIPS    = 12,
    parameter logic [11:0] SYNC_WORD    = 12'h03F
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        START,
    input  logic [1:0]  RUN_MODE,
    input  logic [11:0] DATA_IN,
    input  logic        DATA_VALID,
    output logic [1:0]  PATTERN,
    output logic        DLY_RST,
    output logic        DLY_INC,
    output logic        BITSLIP,
    output logic [4:0]  TAP,
    output logic        DONE,
    output logic [1:0]  ERROR
);

    localparam int         SLIP_W   = $clog2(MAX_SLIPS + 1);
    localparam logic [4:0] LAST_TAP = 5'(NUM_TAPS - 1);

    state_t            state, state_n;
    logic [4:0]        tap, tap_n;
    logic [4:0]        first, first_n;
    logic [4:0]        last, last_n;
    logic              win, win_n;
    logic [SLIP_W-1:0] slip_cnt, slip_n;
    logic [1:0]        err, err_n;
    logic              phase, phase_n;

    logic chk_active, chk_sync, chk_match;
    logic settle_done, pass, fail;

    assign chk_sync   = (state == SYNC_SETTLE) || (state == SYNC_CHECK);
    assign chk_active = chk_sync || (state == SCAN_SETTLE) || (state == SCAN_CHECK);
    assign chk_match  = chk_sync ? (DATA_IN == SYNC_WORD) : is_deskew_word(DATA_IN);

    adc_word_checker #(
        .SETTLE_WORDS (SETTLE_WORDS),
        .CHECK_WORDS  (CHECK_WORDS)
    ) u_checker (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .active      (chk_active),
        .valid       (DATA_VALID),
        .match       (chk_match),
        .settle_done (settle_done),
        .pass        (pass),
        .fail        (fail)
    );

    assign TAP   = tap;
    assign ERROR = err;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state;
        tap_n   = tap;
        first_n = first;
        last_n  = last;
        win_n   = win;
        slip_n  = slip_cnt;
        err_n   = err;
        phase_n = phase;
        PATTERN = PAT_DESKEW;
        DLY_RST = 1'b0;
        DLY_INC = 1'b0;
        BITSLIP = 1'b0;
        DONE    = 1'b0;

        case (state)
            IDLE, FAIL: begin
                if (START) begin
                    state_n = DRST;
                    err_n   = ERR_NONE;
                end
            end
            RUN: begin
                PATTERN = RUN_MODE;
                DONE    = 1'b1;
                if (START) state_n = DRST;
            end
            DRST: begin
                DLY_RST = 1'b1;
                tap_n   = '0;
                first_n = '0;
                last_n  = '0;
                win_n   = 1'b0;
                slip_n  = '0;
                state_n = SCAN_SETTLE;
            end
            SCAN_SETTLE: if (settle_done) state_n = SCAN_CHECK;
            SCAN_CHECK: begin
                // The window is the first run of good taps; the first bad tap after it closes it.
                if (pass) begin
                    if (!win) first_n = tap;
                    last_n  = tap;
                    win_n   = 1'b1;
                    state_n = (tap == LAST_TAP) ? CRST : SCAN_STEP;
                end else if (fail) begin
                    if (win) begin
                        state_n = CRST;
                    end else if (tap == LAST_TAP) begin
                        state_n = FAIL;
                        err_n   = ERR_NO_WINDOW;
                    end else begin
                        state_n = SCAN_STEP;
                    end
                end
            end
            SCAN_STEP: begin
                DLY_INC = 1'b1;
                tap_n   = tap + 5'd1;
                state_n = SCAN_SETTLE;
            end
            CRST: begin
                DLY_RST = 1'b1;
                tap_n   = '0;
                phase_n = 1'b0;
                state_n = CSTEP;
            end
            CSTEP: begin
                // Alternate idle and increment cycles so DLY_INC never pulses back to back.
                if (tap == centre_tap(first, last)) begin
                    state_n = SYNC_SETTLE;
                end else if (phase) begin
                    DLY_INC = 1'b1;
                    tap_n   = tap + 5'd1;
                    phase_n = 1'b0;
                end else begin
                    phase_n = 1'b1;
                end
            end
            SYNC_SETTLE: begin
                PATTERN = PAT_SYNC;
                if (settle_done) state_n = SYNC_CHECK;
            end
            SYNC_CHECK: begin
                PATTERN = PAT_SYNC;
                if (pass) begin
                    state_n = RUN;
                    err_n   = ERR_NONE;
                end else if (fail) begin
                    if (slip_cnt == SLIP_W'(MAX_SLIPS)) begin
                        state_n = FAIL;
                        err_n   = ERR_NO_SYNC;
                    end else begin
                        state_n = SLIP;
                    end
                end
            end
            SLIP: begin
                PATTERN = PAT_SYNC;
                BITSLIP = 1'b1;
                slip_n  = slip_cnt + 1'b1;
                state_n = SYNC_SETTLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= IDLE;
            tap      <= '0;
            first    <= '0;
            last     <= '0;
            win      <= 1'b0;
            slip_cnt <= '0;
            err      <= ERR_NONE;
            phase    <= 1'b0;
        end else begin
            state    <= state_n;
            tap      <= tap_n;
            first    <= first_n;
            last     <= last_n;
            win      <= win_n;
            slip_cnt <= slip_n;
            err      <= err_n;
            phase    <= phase_n;
        end
    end

endmodule

// File: tb/tb_adc_align_ctrl.sv
// Bench for adc_align_ctrl: an ADC model answers delay/bitslip pulses, training
// outcomes are queued as expectations and compared when training completes.
module tb_adc_align_ctrl;

    logic        CLK;
    logic        RSTn;
    logic        START;
    logic [1:0]  RUN_MODE;
    logic [11:0] DATA_IN;
    logic        DATA_VALID;
    logic [1:0]  PATTERN;
    logic        DLY_RST;
    logic        DLY_INC;
    logic        BITSLIP;
    logic [4:0]  TAP;
    logic        DONE;
    logic [1:0]  ERROR;

    adc_align_ctrl dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .START      (START),
        .RUN_MODE   (RUN_MODE),
        .DATA_IN    (DATA_IN),
        .DATA_VALID (DATA_VALID),
        .PATTERN    (PATTERN),
        .DLY_RST    (DLY_RST),
        .DLY_INC    (DLY_INC),
        .BITSLIP    (BITSLIP),
        .TAP        (TAP),
        .DONE       (DONE),
        .ERROR      (ERROR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        string      name;
        logic       done;
        logic [1:0] err;
        logic [4:0] tap;
        logic [1:0] pat;
        int         incs;
        int         rsts;
        int         slips;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // ADC model configuration, written by the stimulus process.
    int good_lo    = 0;
    int good_hi    = -1;
    int sync_slips = 0;
    int valid_div  = 1;
    int m_tap      = 0;
    int m_slips    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input string name, input logic done, input logic [1:0] err,
                        input logic [4:0] tap, input logic [1:0] pat,
                        input int incs, input int rsts, input int slips);
        exp_t e;
        e.name = name; e.done = done; e.err = err; e.tap = tap; e.pat = pat;
        e.incs = incs; e.rsts = rsts; e.slips = slips;
        sb.push_back(e);
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL %s_timeout: %0d results pending after %0d cycles", name, sb.size(), n);
            sb.delete();
        end
        @(negedge CLK);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pattern"}, 32'(PATTERN), 32'd0);
        check({tag, "_dly_rst"}, 32'(DLY_RST), 32'd0);
        check({tag, "_dly_inc"}, 32'(DLY_INC), 32'd0);
        check({tag, "_bitslip"}, 32'(BITSLIP), 32'd0);
        check({tag, "_tap"},     32'(TAP),     32'd0);
        check({tag, "_done"},    32'(DONE),    32'd0);
        check({tag, "_error"},   32'(ERROR),   32'd0);
    endtask

    // ADC model: tracks its own delay tap and slip count from the pulses and drives words.
    initial begin
        int cyc;
        int word_idx;
        logic good;
        cyc = 0;
        word_idx = 0;
        DATA_IN = 12'h000;
        DATA_VALID = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RSTn) begin
                m_tap = 0;
                m_slips = 0;
                cyc = 0;
                DATA_VALID = 1'b0;
            end else begin
                if (DLY_RST) begin
                    m_tap = 0;
                    m_slips = 0;
                end
                if (DLY_INC) m_tap++;
                if (BITSLIP) m_slips++;
                cyc++;
                DATA_VALID = ((cyc % valid_div) == 0);
                if (DATA_VALID) word_idx++;
                case (PATTERN)
                    2'b00: begin
                        good = (m_tap >= good_lo) && (m_tap <= good_hi);
                        if (good || (word_idx % 5) != 4)
                            DATA_IN = ((word_idx % 2) == 1) ? 12'h555 : 12'hAAA;
                        else
                            DATA_IN = 12'h5A5;
                    end
                    2'b01:   DATA_IN = (m_slips >= sync_slips) ? 12'h03F : 12'h0FC;
                    default: DATA_IN = 12'h000;
                endcase
            end
        end
    end

    // Monitor: counts pulses and compares each training outcome against the queue.
    initial begin
        int incs, rsts, slips;
        logic prev_any, pulse_bad, prev_done, any;
        logic [1:0] prev_err;
        exp_t e;
        incs = 0; rsts = 0; slips = 0;
        prev_any = 1'b0; pulse_bad = 1'b0; prev_done = 1'b0; prev_err = 2'b00;
        forever begin
            @(negedge CLK);
            if (!RSTn) begin
                incs = 0; rsts = 0; slips = 0;
                prev_any = 1'b0; pulse_bad = 1'b0; prev_done = 1'b0; prev_err = 2'b00;
            end else begin
                any = DLY_RST | DLY_INC | BITSLIP;
                if (int'(DLY_RST) + int'(DLY_INC) + int'(BITSLIP) > 1) pulse_bad = 1'b1;
                if (any && prev_any) pulse_bad = 1'b1;
                prev_any = any;
                incs  += int'(DLY_INC);
                rsts  += int'(DLY_RST);
                slips += int'(BITSLIP);
                if ((DONE && !prev_done) || (ERROR != 2'b00 && prev_err == 2'b00)) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_completion: done=%0b error=%0b with no result queued", DONE, ERROR);
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_done"},    32'(DONE),    32'(e.done));
                        check({e.name, "_error"},   32'(ERROR),   32'(e.err));
                        check({e.name, "_tap"},     32'(TAP),     32'(e.tap));
                        check({e.name, "_pattern"}, 32'(PATTERN), 32'(e.pat));
                        check({e.name, "_dly_inc"}, 32'(incs),    32'(e.incs));
                        check({e.name, "_dly_rst"}, 32'(rsts),    32'(e.rsts));
                        check({e.name, "_bitslip"}, 32'(slips),   32'(e.slips));
                        check({e.name, "_pulse_rules"}, 32'(pulse_bad), 32'd0);
                    end
                    incs = 0; rsts = 0; slips = 0; pulse_bad = 1'b0;
                end
                prev_done = DONE;
                prev_err = ERROR;
            end
        end
    end

    initial begin
        int n;
        RSTn = 1'b0;
        START = 1'b0;
        RUN_MODE = 2'b10;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RSTn = 1'b1;

        // Window 10..20, sync after 3 slips: 21 scan steps + 15 centring steps.
        good_lo = 10; good_hi = 20; sync_slips = 3; valid_div = 1;
        push("eye_10_20", 1'b1, 2'b00, 5'd15, 2'b10, 36, 2, 3);
        pulse_start();
        wait_idle("eye_10_20", 20000);

        RUN_MODE = 2'b11;
        @(negedge CLK);
        check("run_mode_follow", 32'(PATTERN), 32'h3);
        check("done_in_run", 32'(DONE), 32'd1);
        push("retrain_from_run", 1'b1, 2'b00, 5'd15, 2'b11, 36, 2, 3);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check("done_drop_after_start", 32'(DONE), 32'd0);
        wait_idle("retrain_from_run", 20000);

        // No good tap anywhere: all 32 taps checked, then no-window error.
        good_lo = 99; good_hi = -1; RUN_MODE = 2'b10;
        push("all_bad", 1'b0, 2'b01, 5'd31, 2'b00, 31, 1, 0);
        pulse_start();
        wait_idle("all_bad", 20000);

        // Window closes at the last tap; centre (25+31)>>1 = 28.
        good_lo = 25; good_hi = 31; sync_slips = 0;
        push("eye_25_31", 1'b1, 2'b00, 5'd28, 2'b10, 59, 2, 0);
        pulse_start();
        wait_idle("eye_25_31", 20000);

        // Sync word never appears: twelve bitslips, then sync error.
        good_lo = 4; good_hi = 9; sync_slips = 99;
        push("no_sync", 1'b0, 2'b10, 5'd6, 2'b00, 16, 2, 12);
        pulse_start();
        wait_idle("no_sync", 20000);
        repeat (20) @(negedge CLK);
        check("error_held", 32'(ERROR), 32'h2);
        check("fail_pattern_held", 32'(PATTERN), 32'h0);

        // Reset asserted mid-check at tap 7 aborts at once; a new START begins at tap 0.
        good_lo = 5; good_hi = 20; sync_slips = 0;
        pulse_start();
        n = 0;
        while (m_tap != 7 && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        if (m_tap != 7) begin
            n_checks++;
            $display("FAIL reach_tap7_timeout: model tap %0d, required 7", m_tap);
        end
        repeat (14) @(negedge CLK);
        #1 RSTn = 1'b0;
        #1 check_reset_outputs("midscan_reset");
        @(negedge CLK);
        RSTn = 1'b1;
        push("after_reset", 1'b1, 2'b00, 5'd12, 2'b10, 33, 2, 0);
        pulse_start();
        check("restart_tap0", 32'(TAP), 32'd0);
        check("restart_dly_rst", 32'(DLY_RST), 32'd1);
        wait_idle("after_reset", 20000);

        // Sparse DATA_VALID plus an ignored START while settling: same outcome as the first run.
        good_lo = 10; good_hi = 20; sync_slips = 3; valid_div = 4;
        push("sparse_valid", 1'b1, 2'b00, 5'd15, 2'b10, 36, 2, 3);
        pulse_start();
        repeat (10) @(negedge CLK);
        pulse_start();
        wait_idle("sparse_valid", 40000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
